// File: rtl/snow64_pipe_stage_wb_queued.sv
// -----------------------------------------------------------------------------
// snow64_pipe_stage_wb_queued
// Queued writeback stage. Retiring EX instructions that write the LAR file are
// decoded and buffered in a DEPTH-entry FIFO. An issue FSM hands them to the
// control unit one at a time. ALU writes finish in the cycle after issue.
// Loads and stores wait for in_wr_valid. IF/ID is stalled only while the FIFO
// is full.
//
// ALU entries carry data_type 0 and int_type_size 0. The oper decode applies
// only to loads and stores.
//
// Optional feature: define SNOW64_WB_QUEUED_TIMEOUT_EN to add the
// TIMEOUT_CYCLES parameter and the sticky out_timeout output. When the timer
// expires, a load or store that is still waiting is dropped.
// -----------------------------------------------------------------------------
module snow64_pipe_stage_wb_queued #(
   parameter int DEPTH       = 4,
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 64,
   parameter int INDEX_WIDTH = 4
`ifdef SNOW64_WB_QUEUED_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 256
`endif
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_ex_valid,
   input  logic [2:0]               in_ex_group,
   input  logic [3:0]               in_ex_oper,
   input  logic [INDEX_WIDTH-1:0]   in_ex_ra_index,
   input  logic [DATA_WIDTH-1:0]    in_ex_computed_data,
   input  logic [ADDR_WIDTH-1:0]    in_ex_ldst_addr,
   output logic                     out_stall,
   output logic                     out_wr_req,
   output logic [1:0]               out_wr_write_type,
   output logic [INDEX_WIDTH-1:0]   out_wr_index,
   output logic [DATA_WIDTH-1:0]    out_wr_non_ldst_data,
   output logic [ADDR_WIDTH-1:0]    out_wr_ldst_addr,
   output logic [1:0]               out_wr_data_type,
   output logic [1:0]               out_wr_int_type_size,
   input  logic                     in_wr_valid,
   output logic [$clog2(DEPTH):0]   out_count,
   output logic                     out_busy
`ifdef SNOW64_WB_QUEUED_TIMEOUT_EN
   ,
   output logic                     out_timeout
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] WT_ONLY_DATA = 2'd0;
   localparam logic [1:0] WT_LD        = 2'd1;
   localparam logic [1:0] WT_ST        = 2'd2;

   localparam logic [1:0] DT_UNSGN     = 2'd0;
   localparam logic [1:0] DT_BFLOAT16  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUED,
      ST_WAIT_VALID
   } state_t;

   typedef struct packed {
      logic [1:0]             write_type;
      logic [INDEX_WIDTH-1:0] index;
      logic [DATA_WIDTH-1:0]  data;
      logic [ADDR_WIDTH-1:0]  addr;
      logic [1:0]             data_type;
      logic [1:0]             int_size;
   } entry_t;

   entry_t         mem [DEPTH];
   entry_t         new_entry;
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   state_t         state;
   logic           full;
   logic           writes_lar;
   logic           push;
   logic           pop;
   logic           timeout_hit;

   assign full       = (count == CW'(DEPTH));
   assign writes_lar = (in_ex_group == 3'd0) || (in_ex_group == 3'd2) ||
                       (in_ex_group == 3'd3);
   assign push       = in_ex_valid && writes_lar && !full;
   assign out_stall  = in_ex_valid && full;
   assign out_count  = count;
   assign out_busy   = (count != '0) || (state != ST_IDLE);

   // The head leaves the FIFO when an ALU write finishes its issue cycle,
   // when a load/store completes, or when its wait times out.
   assign pop = ((state == ST_ISSUED) && (out_wr_write_type == WT_ONLY_DATA)) ||
                ((state == ST_WAIT_VALID) && (in_wr_valid || timeout_hit));

`ifdef SNOW64_WB_QUEUED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wait_cnt;

   assign timeout_hit = (state == ST_WAIT_VALID) && !in_wr_valid &&
                        (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Count cycles spent in WaitValid. out_timeout stays set until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt    <= '0;
         out_timeout <= 1'b0;
      end else begin
         if (state == ST_WAIT_VALID) wait_cnt <= wait_cnt + 1'b1;
         else                        wait_cnt <= '0;
         if (timeout_hit) out_timeout <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Decode the EX instruction into a FIFO entry.
   always_comb begin
      // NOTE: default every field first so no path leaves a variable unassigned (no latch).
      new_entry            = '0;
      new_entry.index      = in_ex_ra_index;
      new_entry.data       = in_ex_computed_data;
      new_entry.addr       = in_ex_ldst_addr;
      new_entry.write_type = WT_ONLY_DATA;
      if (in_ex_group == 3'd2 || in_ex_group == 3'd3) begin
         new_entry.write_type = (in_ex_group == 3'd2) ? WT_LD : WT_ST;
         if (in_ex_oper == 4'd8) begin
            new_entry.data_type = DT_BFLOAT16;
            new_entry.int_size  = 2'd1;
         end else if (in_ex_oper[3]) begin
            new_entry.data_type = DT_UNSGN;
            new_entry.int_size  = 2'd3;
         end else begin
            new_entry.data_type = {1'b0, in_ex_oper[0]};
            new_entry.int_size  = in_ex_oper[2:1];
         end
      end
   end

   // FIFO storage write.
   // NOTE: storage has no reset. Only the pointers and count qualify its contents.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= new_entry;
   end

   // Pointers and occupancy. Pointers wrap naturally because DEPTH is 2**PW.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments only.
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Issue FSM. Registered request pulse and output fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                <= ST_IDLE;
         out_wr_req           <= 1'b0;
         out_wr_write_type    <= '0;
         out_wr_index         <= '0;
         out_wr_non_ldst_data <= '0;
         out_wr_ldst_addr     <= '0;
         out_wr_data_type     <= '0;
         out_wr_int_type_size <= '0;
      end else begin
         out_wr_req <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (count != '0) begin
                  out_wr_req           <= 1'b1;
                  out_wr_write_type    <= mem[rd_ptr].write_type;
                  out_wr_index         <= mem[rd_ptr].index;
                  out_wr_non_ldst_data <= mem[rd_ptr].data;
                  out_wr_ldst_addr     <= mem[rd_ptr].addr;
                  out_wr_data_type     <= mem[rd_ptr].data_type;
                  out_wr_int_type_size <= mem[rd_ptr].int_size;
                  state                <= ST_ISSUED;
               end
            end
            ST_ISSUED: begin
               state <= (out_wr_write_type == WT_ONLY_DATA) ? ST_IDLE : ST_WAIT_VALID;
            end
            ST_WAIT_VALID: begin
               if (in_wr_valid || timeout_hit) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
